digit_scan: RTL and testbench



---
 rtl/digit_scan_pkg.sv | 16 +
 rtl/digit_scan_if.sv | 37 +++
 rtl/digit_scan_prescaler.sv | 35 +++
 rtl/digit_scan.sv | 122 ++++++++++++
 tb/tb_digit_scan.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/digit_scan_pkg.sv
// digit_scan shared display constants.
// Digit count, anode encoding and index width for the scanner.
package digit_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 2;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  function automatic logic [NUM_DIGITS-1:0] anode_sel(
    input logic [DIG_W-1:0] idx
  );
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/digit_scan_if.sv
// digit_scan display bus.
// Master is the value producer, slave is the scanner.
interface digit_scan_if;
  import digit_scan_pkg::*;

  logic [15:0]      value_in;
  logic             load;
  logic [3:0]       dp_in;
  logic             blank_lz;
  logic [3:0]       hex_out;
  logic [DIG_W-1:0] digit_idx;
  logic [3:0]       anode_n;
  logic             dp_n;

  modport master (
    output value_in,
    output load,
    output dp_in,
    output blank_lz,
    input  hex_out,
    input  digit_idx,
    input  anode_n,
    input  dp_n
  );

  modport slave (
    input  value_in,
    input  load,
    input  dp_in,
    input  blank_lz,
    output hex_out,
    output digit_idx,
    output anode_n,
    output dp_n
  );

endinterface

// File: rtl/digit_scan_prescaler.sv
// scan_prescaler: modulo-N counter with terminal-count pulse.
// tc is high on the enabled cycle where the count wraps.
module scan_prescaler #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = en && (cnt_q == LAST);

endmodule

// File: rtl/digit_scan.sv
// digit_scan: four-digit multiplexed 7-seg scanner.
// Double-buffered value, guard time and leading-zero blanking.
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 500
) (
  input logic        clk,
  input logic        rst,
  digit_scan_if.slave bus
);

  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int ON_CYC = REFRESH_DIV - GUARD;

  logic [PRE_W-1:0] pre;
  logic             pre_tc;
  logic [DIG_W-1:0] dig;
  logic             frame;

  scan_prescaler #(.N(REFRESH_DIV)) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .cnt (pre),
    .tc  (pre_tc)
  );

  scan_prescaler #(.N(NUM_DIGITS)) u_dig (
    .clk (clk),
    .rst (rst),
    .en  (pre_tc),
    .cnt (dig),
    .tc  (frame)
  );

  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q,  pend_dp_d;
  logic [15:0] act_val_q,  act_val_d;
  logic [3:0]  act_dp_q,   act_dp_d;

  // A load on the boundary cycle lands in active via pend_*_d.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    if (bus.load) begin
      pend_val_d = bus.value_in;
      pend_dp_d  = bus.dp_in;
    end
    if (frame) begin
      act_val_d = pend_val_d;
      act_dp_d  = pend_dp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
    end else begin
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
    end
  end

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  nz_seen;

  always_comb begin
    lz_blank = '0;
    nz_seen  = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      nz_seen     = nz_seen | (act_val_q[4*k +: 4] != 4'h0);
      lz_blank[k] = bus.blank_lz & ~nz_seen;
    end
  end

  logic             lit;
  logic [3:0]       hex_q,  hex_d;
  logic [DIG_W-1:0] idx_q,  idx_d;
  logic [3:0]       an_q,   an_d;
  logic             dpn_q,  dpn_d;

  always_comb begin
    lit   = (32'(pre) < 32'(ON_CYC)) && !lz_blank[dig];
    hex_d = act_val_q[4*dig +: 4];
    idx_d = dig;
    an_d  = ANODE_OFF;
    dpn_d = 1'b1;
    if (lit) begin
      an_d  = anode_sel(dig);
      dpn_d = ~act_dp_q[dig];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hex_q <= '0;
      idx_q <= '0;
      an_q  <= ANODE_OFF;
      dpn_q <= 1'b1;
    end else begin
      hex_q <= hex_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      dpn_q <= dpn_d;
    end
  end

  assign bus.hex_out   = hex_q;
  assign bus.digit_idx = idx_q;
  assign bus.anode_n   = an_q;
  assign bus.dp_n      = dpn_q;

endmodule

// File: tb/tb_digit_scan.sv
// tb_digit_scan: table-driven frame checks for digit_scan.
// REFRESH_DIV=8, GUARD=2: 8-cycle slots, 32-cycle frames.
module tb_digit_scan;
  import digit_scan_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  digit_scan_if bus ();

  digit_scan #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // mode 0: pending load, 1: boundary load, 2: mid-frame load
  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] val;
    logic [3:0]  dp;
    logic        blz;
    logic [15:0] hex;
    logic [15:0] an;
    logic [3:0]  dpn;
  } vec_t;

  vec_t vecs [8];
  vec_t zero_v;
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Output after step k reflects slot (k/8)%4, position k%8.
  task automatic check_cycle(vec_t v);
    int k, p, s;
    logic [3:0] ean;
    logic edp;
    k   = cyc - 1;
    p   = k % 8;
    s   = (k / 8) % 4;
    ean = (p < 6) ? v.an[4*s +: 4] : 4'hF;
    edp = (p < 6) ? v.dpn[s] : 1'b1;
    chk("hex_out", 16'(bus.hex_out), 16'(v.hex[4*s +: 4]));
    chk("digit_idx", 16'(bus.digit_idx), 16'(s));
    chk("anode_n", 16'(bus.anode_n), 16'(ean));
    chk("dp_n", 16'(bus.dp_n), 16'(edp));
  endtask

  task automatic check_frame(vec_t v);
    repeat (32) begin
      step();
      check_cycle(v);
    end
  endtask

  task automatic apply_load(vec_t v);
    bus.value_in = v.val;
    bus.dp_in    = v.dp;
    bus.blank_lz = v.blz;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic check_reset_outs(string tag);
    chk({tag, "_anode"}, 16'(bus.anode_n), 16'hF);
    chk({tag, "_idx"}, 16'(bus.digit_idx), 16'h0);
    chk({tag, "_hex"}, 16'(bus.hex_out), 16'h0);
    chk({tag, "_dp"}, 16'(bus.dp_n), 16'h1);
  endtask

  initial begin
    vecs[0] = '{2'd0, 16'h1234, 4'h0, 1'b0, 16'h1234, 16'h7BDE, 4'hF};
    vecs[1] = '{2'd2, 16'hABCD, 4'h0, 1'b0, 16'hABCD, 16'h7BDE, 4'hF};
    vecs[2] = '{2'd1, 16'h00F0, 4'h0, 1'b0, 16'h00F0, 16'h7BDE, 4'hF};
    vecs[3] = '{2'd0, 16'h0050, 4'h0, 1'b1, 16'h0050, 16'hFFDE, 4'hF};
    vecs[4] = '{2'd0, 16'h0000, 4'h0, 1'b1, 16'h0000, 16'hFFFE, 4'hF};
    vecs[5] = '{2'd0, 16'h0700, 4'h0, 1'b1, 16'h0700, 16'hFBDE, 4'hF};
    vecs[6] = '{2'd0, 16'h1234, 4'h4, 1'b0, 16'h1234, 16'h7BDE, 4'hB};
    vecs[7] = '{2'd0, 16'h5678, 4'h0, 1'b0, 16'h5678, 16'h7BDE, 4'hF};
    zero_v  = '{2'd0, 16'h0000, 4'h0, 1'b0, 16'h0000, 16'h7BDE, 4'hF};

    bus.value_in = '0;
    bus.dp_in    = '0;
    bus.blank_lz = 1'b0;
    bus.load     = 1'b0;

    rst = 1'b1;
    repeat (3) step();
    check_reset_outs("reset");
    rst = 1'b0;
    cyc = 0;

    for (int i = 0; i < 8; i++) begin
      unique case (vecs[i].mode)
        2'd0: begin
          apply_load(vecs[i]);
          while (cyc % 32 != 0) step();
        end
        2'd1: begin
          while (cyc % 32 != 31) step();
          apply_load(vecs[i]);
        end
        default: begin
          while (cyc % 32 != 9) begin
            step();
            check_cycle(vecs[i-1]);
          end
          bus.value_in = vecs[i].val;
          bus.dp_in    = vecs[i].dp;
          bus.blank_lz = vecs[i].blz;
          bus.load     = 1'b1;
          step();
          bus.load     = 1'b0;
          check_cycle(vecs[i-1]);
          while (cyc % 32 != 0) begin
            step();
            check_cycle(vecs[i-1]);
          end
        end
      endcase
      check_frame(vecs[i]);
    end

    // Pending load then reset in slot 2 ON: both get discarded.
    while (cyc % 32 != 17) step();
    bus.value_in = 16'h9999;
    bus.dp_in    = 4'hF;
    bus.blank_lz = 1'b0;
    bus.load     = 1'b1;
    step();
    bus.load = 1'b0;
    rst = 1'b1;
    step();
    check_reset_outs("midrst");
    rst = 1'b0;
    cyc = 0;
    check_frame(zero_v);
    check_frame(zero_v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
